// File: rtl/temp_spi_reader.sv
// temp_spi_reader: runs one SPI mode-0 read frame against the temperature
// sensor for each falling edge of the controller's CS_n request. It captures
// NBITS bits MSB-first and answers with a single-cycle temp_done pulse.
// Handshake: a frame starts when CS_n=0 is sampled in IDLE. CS_n=1 sampled in
// SETUP/SHIFT/HOLD aborts the frame. After DONE the request must be released
// (CS_n=1) before another frame can start.
module temp_spi_reader #(
    parameter int CLK_DIV  = 10,
    parameter int NBITS    = 16,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4
) (
    input  logic        clk_fix,
    input  logic        rst_fix,
    input  logic        CS_n,
    input  logic        temp_so,
    output logic        temp_sck,
    output logic        temp_cs_n,
    output logic [15:0] temp_data,
    output logic        temp_done,
    output logic        temp_busy,
    output logic [7:0]  temp_count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DONE    = 3'd4,
        ST_WAITREL = 3'd5
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [15:0] div_cnt;    // SCK half-period divider
    logic [15:0] phase_cnt;  // shared by SETUP and HOLD, cleared between them
    logic [4:0]  bit_cnt;    // SCK rises seen in this frame
    logic [15:0] shreg;      // right-justified capture register

    logic        div_tc;
    logic        setup_tc;
    logic        hold_tc;
    logic        last_fall;

    assign div_tc    = (div_cnt == 16'(CLK_DIV - 1));
    assign setup_tc  = (phase_cnt == 16'(CS_SETUP - 1));
    assign hold_tc   = (phase_cnt == 16'(CS_HOLD - 1));
    // The falling edge that closes the frame: SCK is high, divider expires,
    // and all NBITS rises have already been taken.
    assign last_fall = (state == ST_SHIFT) && div_tc && temp_sck &&
                       (bit_cnt == 5'(NBITS));

    // State register
    always_ff @(posedge clk_fix or posedge rst_fix) begin
        if (rst_fix) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; CS_n high in any active sensor phase aborts the frame
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (!CS_n) next_state = ST_SETUP;
            end
            ST_SETUP: begin
                if (CS_n)          next_state = ST_IDLE;
                else if (setup_tc) next_state = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (CS_n)           next_state = ST_IDLE;
                else if (last_fall) next_state = ST_HOLD;
            end
            ST_HOLD: begin
                if (CS_n)         next_state = ST_IDLE;
                else if (hold_tc) next_state = ST_DONE;
            end
            ST_DONE: begin
                next_state = ST_WAITREL;
            end
            ST_WAITREL: begin
                if (CS_n) next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State-decoded outputs; chip select is low only while talking to the sensor
    always_comb begin
        temp_cs_n = 1'b1;
        temp_busy = 1'b1;
        case (state)
            ST_SETUP, ST_SHIFT, ST_HOLD: temp_cs_n = 1'b0;
            default:                     temp_cs_n = 1'b1;
        endcase
        if (state == ST_IDLE) temp_busy = 1'b0;
    end

    // Datapath: SCK generation, bit capture, phase counting and result update
    always_ff @(posedge clk_fix or posedge rst_fix) begin
        if (rst_fix) begin
            temp_sck   <= 1'b0;
            div_cnt    <= '0;
            phase_cnt  <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            temp_data  <= '0;
            temp_done  <= 1'b0;
            temp_count <= '0;
        end else begin
            temp_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    temp_sck  <= 1'b0;
                    div_cnt   <= '0;
                    phase_cnt <= '0;
                    bit_cnt   <= '0;
                    if (!CS_n) shreg <= '0;
                end
                ST_SETUP: begin
                    // Clear on exit so HOLD starts its count from zero
                    if (setup_tc) phase_cnt <= '0;
                    else          phase_cnt <= phase_cnt + 16'd1;
                end
                ST_SHIFT: begin
                    if (CS_n) begin
                        temp_sck <= 1'b0;
                    end else if (div_tc) begin
                        div_cnt  <= '0;
                        temp_sck <= ~temp_sck;
                        // Rising edge: take the bit the sensor set up on the last fall
                        if (!temp_sck) begin
                            shreg   <= {shreg[14:0], temp_so};
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                ST_HOLD: begin
                    phase_cnt <= phase_cnt + 16'd1;
                end
                ST_DONE: begin
                    temp_data  <= shreg;
                    temp_done  <= 1'b1;
                    temp_count <= temp_count + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
